mult_mux4: RTL and testbench



---
 rtl/mult_pkg.sv | 9 +
 rtl/mult_mux4_if.sv | 26 ++
 rtl/mux4_comb.sv | 22 ++
 rtl/mult_mux4.sv | 50 +++++
 tb/tb_mult_mux4.sv | 114 +++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared select type and constants for the registered 4:1 mux
package mult_pkg;
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_I0 = 2'b00;
    localparam sel_t SEL_I1 = 2'b01;
    localparam sel_t SEL_I2 = 2'b10;
    localparam sel_t SEL_I3 = 2'b11;
    localparam logic [7:0] CHG_CNT_MAX = 8'd255;
endpackage

// File: rtl/mult_mux4_if.sv
// mult_mux4_if: data/select inputs and registered outputs of mult_mux4; MULT_SEL_CHG_EN adds change tracking
interface mult_mux4_if;
    import mult_pkg::*;
    logic i0, i1, i2, i3;
    logic s0, s1;
    logic y;
    sel_t sel_q;
`ifdef MULT_SEL_CHG_EN
    logic sel_chg;
    logic [7:0] chg_cnt;
`endif
    modport master(
        output i0, i1, i2, i3, s0, s1,
        input y, sel_q
`ifdef MULT_SEL_CHG_EN
        , input sel_chg, chg_cnt
`endif
    );
    modport slave(
        input i0, i1, i2, i3, s0, s1,
        output y, sel_q
`ifdef MULT_SEL_CHG_EN
        , output sel_chg, chg_cnt
`endif
    );
endinterface

// File: rtl/mux4_comb.sv
// mux4_comb: combinational 4:1 single-bit decode; unknown select drives 0
module mux4_comb
    import mult_pkg::*;
(
    input  sel_t sel,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic y
);
    // full decode; the default arm keeps X/Z selects visible as a forced 0
    always_comb begin
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = 1'b0;
        endcase
    end
endmodule

// File: rtl/mult_mux4.sv
// mult_mux4: registered 4:1 mux with registered select; MULT_SEL_CHG_EN adds change pulse and saturating counter
module mult_mux4
    import mult_pkg::*;
(
    input logic clk,
    input logic rst,
    mult_mux4_if.slave bus
);
    sel_t sel;
    sel_t sel_r;
    logic mux_y;
    logic y_r;
    assign sel = {bus.s1, bus.s0};
    mux4_comb u_mux (
        .sel(sel),
        .i0(bus.i0),
        .i1(bus.i1),
        .i2(bus.i2),
        .i3(bus.i3),
        .y(mux_y)
    );
    // register the selected bit together with the select that chose it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_r   <= 1'b0;
            sel_r <= SEL_I0;
        end else begin
            y_r   <= mux_y;
            sel_r <= sel;
        end
    end
    assign bus.y     = y_r;
    assign bus.sel_q = sel_r;
`ifdef MULT_SEL_CHG_EN
    logic chg_r;
    logic [7:0] cnt_r;
    // pulse lands on the same cycle y first reflects the new select; counter holds at max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chg_r <= 1'b0;
            cnt_r <= 8'd0;
        end else begin
            chg_r <= sel != sel_r;
            cnt_r <= (sel != sel_r && cnt_r != CHG_CNT_MAX) ? cnt_r + 8'd1 : cnt_r;
        end
    end
    assign bus.sel_chg = chg_r;
    assign bus.chg_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_mult_mux4.sv
// tb_mult_mux4: table-driven scoreboard bench for mult_mux4 (change tracking checked when MULT_SEL_CHG_EN is defined)
module tb_mult_mux4;
    typedef struct packed {
        logic [3:0] i;
        logic [1:0] sel;
        logic       y;
    } vec_t;
    typedef struct packed {
        logic       y;
        logic [1:0] sel;
        logic       chg;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    mult_mux4_if bus();
    mult_mux4 dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    exp_t q[$];
    logic [1:0] prev = 2'b00;
    logic [7:0] cnt = 8'd0;
    vec_t tbl[24];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = q.pop_front();
            chk("y", {7'd0, bus.y}, {7'd0, e.y});
            chk("sel_q", {6'd0, bus.sel_q}, {6'd0, e.sel});
`ifdef MULT_SEL_CHG_EN
            chk("sel_chg", {7'd0, bus.sel_chg}, {7'd0, e.chg});
            chk("chg_cnt", bus.chg_cnt, e.cnt);
`endif
        end
    endtask

    task automatic step(input logic [3:0] iv, input logic [1:0] sv, input logic ey);
        exp_t e;
        @(negedge clk);
        {bus.i3, bus.i2, bus.i1, bus.i0} = iv;
        {bus.s1, bus.s0} = sv;
        e.y = ey;
        e.sel = sv;
        e.chg = sv != prev;
        if (sv != prev && cnt != 8'd255) cnt = cnt + 8'd1;
        e.cnt = cnt;
        prev = sv;
        q.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_y"}, {7'd0, bus.y}, 8'd0);
        chk({tag, "_sel_q"}, {6'd0, bus.sel_q}, 8'd0);
`ifdef MULT_SEL_CHG_EN
        chk({tag, "_sel_chg"}, {7'd0, bus.sel_chg}, 8'd0);
        chk({tag, "_chg_cnt"}, bus.chg_cnt, 8'd0);
`endif
    endtask

    initial begin
        tbl = '{
            '{4'b0001, 2'b00, 1'b1}, '{4'b0001, 2'b01, 1'b0}, '{4'b0001, 2'b10, 1'b0}, '{4'b0001, 2'b11, 1'b0},
            '{4'b0010, 2'b00, 1'b0}, '{4'b0010, 2'b01, 1'b1}, '{4'b0010, 2'b10, 1'b0}, '{4'b0010, 2'b11, 1'b0},
            '{4'b0100, 2'b00, 1'b0}, '{4'b0100, 2'b01, 1'b0}, '{4'b0100, 2'b10, 1'b1}, '{4'b0100, 2'b11, 1'b0},
            '{4'b1000, 2'b00, 1'b0}, '{4'b1000, 2'b01, 1'b0}, '{4'b1000, 2'b10, 1'b0}, '{4'b1000, 2'b11, 1'b1},
            '{4'b1110, 2'b00, 1'b0}, '{4'b0111, 2'b11, 1'b0}, '{4'b1011, 2'b10, 1'b0}, '{4'b1101, 2'b01, 1'b0},
            '{4'b0000, 2'b10, 1'b0}, '{4'b0100, 2'b10, 1'b1}, '{4'b0000, 2'b00, 1'b0}, '{4'b0100, 2'b10, 1'b1}
        };
        {bus.i3, bus.i2, bus.i1, bus.i0} = 4'b0000;
        {bus.s1, bus.s0} = 2'b00;
        #1 rst = 1'b1;
        #1 reset_checks("por");
        @(negedge clk);
        rst = 1'b0;
        step(4'b0010, 2'b01, 1'b1);
        for (int k = 0; k < 24; k++) step(tbl[k].i, tbl[k].sel, tbl[k].y);
        step(4'b0001, 2'b00, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_checks("async_rst");
        @(negedge clk);
        rst = 1'b0;
        prev = 2'b00;
        cnt = 8'd0;
        step(4'b1000, 2'b11, 1'b1);
        step(4'b0000, 2'b11, 1'b0);
        for (int n = 0; n < 300; n++) step(4'b0001, {1'b0, n[0]}, ~n[0]);
`ifdef MULT_SEL_CHG_EN
        chk("cnt_saturated", bus.chg_cnt, 8'd255);
`endif
        step(4'b0001, 2'b01, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
